// File: rtl/wb_unit.sv
// Writeback stage: MA/WB latch, writeback value select, 16x32 register file with write bypass, retire counter.
// Latency: instruction latched at edge N, written and counted at edge N+1, bypass-visible during cycle N+1.
// Backpressure: stall holds the latch and suppresses write/retire; flush inserts a bubble; stall beats flush.
module wb_unit #(
  parameter int NREG = 16,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ma_valid,
  input  logic [31:0]     ma_pc,
  input  logic [31:0]     ma_alu,
  input  logic [31:0]     ma_ld,
  input  logic [3:0]      ma_rd,
  input  logic            ma_isLd,
  input  logic            ma_isWb,
  input  logic            ma_isCall,
  input  logic            stall,
  input  logic            flush,
  input  logic [3:0]      rs1_addr,
  input  logic [3:0]      rs2_addr,
  output logic [31:0]     rs1_data,
  output logic [31:0]     rs2_data,
  output logic            wb_valid,
  output logic [3:0]      wb_rd,
  output logic [31:0]     wb_data,
  output logic [CNTW-1:0] retired
);

  localparam logic [3:0] RA = 4'd15;

  logic            valid_q;
  logic            wen_q;
  logic [3:0]      rd_q;
  logic [31:0]     data_q;
  logic [CNTW-1:0] retired_q;
  logic [31:0]     regs [NREG];

  logic            do_write;
  logic            do_retire;
  logic            next_valid;
  logic [3:0]      next_rd;
  logic [31:0]     next_data;

  assign do_write  = wen_q & ~stall;
  assign do_retire = valid_q & ~stall;

  // Writeback value select for the incoming instruction: call > load > alu.
  always_comb begin
    next_valid = ma_valid & ~flush;
    next_rd    = ma_isCall ? RA : ma_rd;
    if (ma_isCall) begin
      next_data = ma_pc + 32'd4;
    end else if (ma_isLd) begin
      next_data = ma_ld;
    end else begin
      next_data = ma_alu;
    end
  end

  // MA/WB pipeline latch; held while stalled so the instruction retires exactly once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      rd_q    <= 4'd0;
      data_q  <= 32'd0;
    end else if (!stall) begin
      valid_q <= next_valid;
      wen_q   <= next_valid & (ma_isWb | ma_isCall);
      rd_q    <= next_rd;
      data_q  <= next_data;
    end
  end

  // Register file write; reset discards any latched write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (do_write) begin
      regs[rd_q] <= data_q;
    end
  end

  // Retired-instruction counter, counts every valid instruction leaving the stage, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (do_retire) begin
      retired_q <= retired_q + CNTW'(1);
    end
  end

  // Read ports with write-through bypass of the write happening on the coming edge.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (do_write && (rd_q == rs1_addr)) begin
      rs1_data = data_q;
    end
    if (do_write && (rd_q == rs2_addr)) begin
      rs2_data = data_q;
    end
  end

  assign wb_valid = wen_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios plus randomized traffic against a behavioural model.
// The counter is built narrow so wrap-around is reachable in a short run.
module tb_wb_unit;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ma_valid;
  logic [31:0]   ma_pc;
  logic [31:0]   ma_alu;
  logic [31:0]   ma_ld;
  logic [3:0]    ma_rd;
  logic          ma_isLd;
  logic          ma_isWb;
  logic          ma_isCall;
  logic          stall;
  logic          flush;
  logic [3:0]    rs1_addr;
  logic [3:0]    rs2_addr;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;
  logic          wb_valid;
  logic [3:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [CW-1:0] retired;

  int n_vec = 0;
  int n_err = 0;

  wb_unit #(.NREG(16), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ma_valid(ma_valid), .ma_pc(ma_pc), .ma_alu(ma_alu), .ma_ld(ma_ld), .ma_rd(ma_rd),
    .ma_isLd(ma_isLd), .ma_isWb(ma_isWb), .ma_isCall(ma_isCall),
    .stall(stall), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .retired(retired)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural registers, one pending instruction, retire count.
  logic [31:0]   m_regs [16];
  logic          p_valid;
  logic          p_wen;
  logic [3:0]    p_rd;
  logic [31:0]   p_data;
  logic [CW-1:0] m_cnt;

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    if (p_wen && !stall && p_rd == a) return p_data;
    return m_regs[a];
  endfunction

  task automatic idle_inputs();
    ma_valid = 0; ma_pc = 0; ma_alu = 0; ma_ld = 0; ma_rd = 0;
    ma_isLd = 0; ma_isWb = 0; ma_isCall = 0; stall = 0; flush = 0;
  endtask

  task automatic present(input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc, input logic isld, input logic iswb, input logic iscall);
    ma_valid = 1; ma_rd = rd; ma_alu = alu; ma_ld = ld; ma_pc = pc;
    ma_isLd = isld; ma_isWb = iswb; ma_isCall = iscall;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      p_valid = 0; p_wen = 0; p_rd = 0; p_data = 0; m_cnt = 0;
    end else if (!stall) begin
      if (p_wen) m_regs[p_rd] = p_data;
      if (p_valid) m_cnt = m_cnt + 1'b1;
      p_valid = ma_valid && !flush;
      p_wen   = p_valid && (ma_isWb || ma_isCall);
      p_rd    = ma_isCall ? 4'd15 : ma_rd;
      p_data  = ma_isCall ? ma_pc + 32'd4 : (ma_isLd ? ma_ld : ma_alu);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int c = 0; c < 2; c++) begin
      present($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      stall = $urandom; flush = $urandom;
      tick();
    end
    rst_n = 1;
    idle_inputs();
    #1;
    n_vec++;
    if (retired !== 0) begin n_err++; $display("FAIL reset_retired got %h want 0", retired); end
    n_vec++;
    if (wb_valid !== 0 || wb_rd !== 0 || wb_data !== 0) begin
      n_err++; $display("FAIL reset_wb got v=%b rd=%h d=%h want 0/0/0", wb_valid, wb_rd, wb_data);
    end
    for (int a = 0; a < 16; a++) begin
      rs1_addr = a[3:0]; rs2_addr = 4'(15 - a);
      #1;
      n_vec++;
      if (rs1_data !== 0 || rs2_data !== 0) begin
        n_err++; $display("FAIL reset_regs r%0d got %h/%h want 0", a, rs1_data, rs2_data);
      end
    end
  endtask

  task automatic test_alu();
    logic [CW-1:0] c0;
    c0 = m_cnt;
    present(4'd3, 32'h0000_00AB, 32'h1234_5678, 32'h100, 0, 1, 0);
    tick();
    idle_inputs();
    rs1_addr = 3;
    #1;
    n_vec++;
    if (wb_valid !== 1 || wb_rd !== 3 || wb_data !== 32'hAB) begin
      n_err++; $display("FAIL alu_fwd got v=%b rd=%h d=%h want 1/3/ab", wb_valid, wb_rd, wb_data);
    end
    n_vec++;
    if (rs1_data !== 32'hAB) begin n_err++; $display("FAIL alu_bypass got %h want ab", rs1_data); end
    tick();
    n_vec++;
    if (rs1_data !== 32'hAB) begin n_err++; $display("FAIL alu_array got %h want ab", rs1_data); end
    n_vec++;
    if (retired !== CW'(c0 + 1)) begin n_err++; $display("FAIL alu_retired got %h want %h", retired, CW'(c0 + 1)); end
  endtask

  task automatic test_load_call();
    logic [31:0] r5_old;
    present(4'd4, 32'h10, 32'hDEAD_BEEF, 32'h200, 1, 1, 0);
    tick();
    idle_inputs();
    tick();
    rs1_addr = 4; #1;
    n_vec++;
    if (rs1_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_sel got %h want deadbeef", rs1_data); end
    r5_old = m_regs[5];
    // Call with load flag also set: call must win; isWb low still writes.
    present(4'd5, 32'h77, 32'h88, 32'h0000_0040, 1, 0, 1);
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (wb_valid !== 1 || wb_rd !== 15 || wb_data !== 32'h44) begin
      n_err++; $display("FAIL call_fwd got v=%b rd=%h d=%h want 1/f/44", wb_valid, wb_rd, wb_data);
    end
    tick();
    rs1_addr = 15; rs2_addr = 5; #1;
    n_vec++;
    if (rs1_data !== 32'h44 || rs2_data !== r5_old) begin
      n_err++; $display("FAIL call_regs got r15=%h r5=%h want 44/%h", rs1_data, rs2_data, r5_old);
    end
  endtask

  task automatic test_stall_flush();
    logic [CW-1:0] c0;
    logic [31:0]   r7_old;
    r7_old = m_regs[7];
    present(4'd7, 32'h55, 32'h0, 32'h0, 0, 1, 0);
    tick();
    c0 = m_cnt;
    rs1_addr = 7;
    for (int c = 0; c < 3; c++) begin
      present(4'd8, 32'hAAAA_0000 | c, 32'h0, 32'h0, 0, 1, 0);
      stall = 1; flush = (c == 1);
      #1;
      n_vec++;
      if (rs1_data !== r7_old || retired !== c0 || wb_data !== 32'h55 || wb_valid !== 1) begin
        n_err++; $display("FAIL stall_hold c%0d got r7=%h cnt=%h d=%h v=%b want %h/%h/55/1",
                          c, rs1_data, retired, wb_data, wb_valid, r7_old, c0);
      end
      tick();
    end
    stall = 0; flush = 1;
    #1;
    n_vec++;
    if (rs1_data !== 32'h55) begin n_err++; $display("FAIL release_bypass got %h want 55", rs1_data); end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (rs1_data !== 32'h55 || retired !== CW'(c0 + 1) || wb_valid !== 0) begin
      n_err++; $display("FAIL flush_release got r7=%h cnt=%h v=%b want 55/%h/0", rs1_data, retired, wb_valid, CW'(c0 + 1));
    end
    tick();
    n_vec++;
    if (retired !== CW'(c0 + 1)) begin n_err++; $display("FAIL bubble_retire got %h want %h", retired, CW'(c0 + 1)); end
  endtask

  task automatic test_nonwrite();
    logic [CW-1:0] c0;
    c0 = m_cnt;
    present(4'd9, 32'hFFFF_0009, 32'h0, 32'h300, 0, 0, 0);   // st
    tick();
    present(4'd10, 32'h0, 32'hCAFE_0000, 32'h304, 1, 0, 0);  // load with isWb low
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (wb_valid !== 0) begin n_err++; $display("FAIL nonwrite_wen got %b want 0", wb_valid); end
    tick();
    for (int a = 0; a < 16; a++) begin
      rs1_addr = a[3:0]; #1;
      n_vec++;
      if (rs1_data !== m_regs[a]) begin n_err++; $display("FAIL nonwrite_regs r%0d got %h want %h", a, rs1_data, m_regs[a]); end
    end
    n_vec++;
    if (retired !== CW'(c0 + 2)) begin n_err++; $display("FAIL nonwrite_retire got %h want %h", retired, CW'(c0 + 2)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      present($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      ma_valid = $urandom_range(0, 4) != 0;
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 6) == 0;
      rs1_addr = $urandom; rs2_addr = (c % 3 == 0) ? p_rd : 4'($urandom);
      #1;
      n_vec++;
      if (wb_valid !== p_wen || wb_rd !== p_rd || wb_data !== p_data || retired !== m_cnt ||
          rs1_data !== exp_read(rs1_addr) || rs2_data !== exp_read(rs2_addr)) begin
        n_err++;
        $display("FAIL random c%0d got v=%b rd=%h d=%h cnt=%h rs1=%h rs2=%h want %b/%h/%h/%h/%h/%h",
                 c, wb_valid, wb_rd, wb_data, retired, rs1_data, rs2_data,
                 p_wen, p_rd, p_data, m_cnt, exp_read(rs1_addr), exp_read(rs2_addr));
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap_reset();
    int budget;
    budget = 0;
    present(4'd1, 32'h1, 32'h0, 32'h0, 0, 0, 0);
    while (m_cnt != {CW{1'b1}} && budget < 600) begin
      tick();
      budget++;
    end
    idle_inputs();
    #1;
    n_vec++;
    if (retired !== {CW{1'b1}}) begin n_err++; $display("FAIL wrap_pre got %h want %h", retired, {CW{1'b1}}); end
    tick();
    n_vec++;
    if (retired !== 0) begin n_err++; $display("FAIL wrap got %h want 0", retired); end
    present(4'd2, 32'h99, 32'h0, 32'h0, 0, 1, 0);
    tick();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    rs1_addr = 2; #1;
    n_vec++;
    if (rs1_data !== 0 || retired !== 0 || wb_valid !== 0) begin
      n_err++; $display("FAIL mid_reset got r2=%h cnt=%h v=%b want 0/0/0", rs1_data, retired, wb_valid);
    end
    tick();
    n_vec++;
    if (rs1_data !== 0) begin n_err++; $display("FAIL mid_reset_after got r2=%h want 0", rs1_data); end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    rs1_addr = 0; rs2_addr = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    p_valid = 0; p_wen = 0; p_rd = 0; p_data = 0; m_cnt = 0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_load_call();
    test_stall_flush();
    test_nonwrite();
    test_random();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
